// File: rtl/simon_ctrl.sv
// simon_ctrl: sequencer that serially loads key/plaintext into the bit-serial SIMON 64/128 core and collects the ciphertext.
// Define SIMON_CTRL_TIMEOUT_EN to add an abort after TIMEOUT_CYCLES cycles in RUN.

module simon_ctrl #(
    parameter int BLOCK_BITS     = 64,
    parameter int KEY_BITS       = 128,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [KEY_BITS-1:0]   key,
    input  logic [BLOCK_BITS-1:0] pt,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [BLOCK_BITS-1:0] ct,
    output logic                  core_data_in,
    output logic [1:0]            core_data_rdy,
    input  logic                  core_cipher_out,
    input  logic                  core_valid
);

    localparam int MAX_KB  = (KEY_BITS > BLOCK_BITS) ? KEY_BITS : BLOCK_BITS;
    localparam int MAX_ALL = (MAX_KB > TIMEOUT_CYCLES) ? MAX_KB : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_ALL) + 1;

    localparam logic [CNT_W-1:0] KEY_LAST    = CNT_W'(KEY_BITS - 1);
    localparam logic [CNT_W-1:0] PT_LAST     = CNT_W'(BLOCK_BITS - 1);
    localparam logic [CNT_W-1:0] UNLOAD_LAST = CNT_W'(BLOCK_BITS - 2);
`ifdef SIMON_CTRL_TIMEOUT_EN
    localparam logic [CNT_W-1:0] RUN_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_KEY  = 2'b01;
    localparam logic [1:0] MODE_PT   = 2'b10;
    localparam logic [1:0] MODE_RUN  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_KEY,
        S_LOAD_PT,
        S_RUN,
        S_UNLOAD,
        S_DONE
    } state_t;

    state_t                r_state,       w_state_nxt;
    logic [CNT_W-1:0]      r_cnt,         w_cnt_nxt;
    logic [KEY_BITS-2:0]   r_key_sr,      w_key_sr_nxt;
    logic [BLOCK_BITS-1:0] r_pt_sr,       w_pt_sr_nxt;
    logic [BLOCK_BITS-2:0] r_ct_sr,       w_ct_sr_nxt;
    logic [BLOCK_BITS-1:0] r_ct,          w_ct_nxt;
    logic                  r_busy,        w_busy_nxt;
    logic                  r_done,        w_done_nxt;
    logic                  r_data_in,     w_data_in_nxt;
    logic [1:0]            r_data_rdy,    w_data_rdy_nxt;
`ifdef SIMON_CTRL_TIMEOUT_EN
    logic                  r_err,         w_err_nxt;
`endif

    // Outputs are registered from next-state values so the core sees each mode/bit a full cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_key_sr_nxt   = r_key_sr;
        w_pt_sr_nxt    = r_pt_sr;
        w_ct_sr_nxt    = r_ct_sr;
        w_ct_nxt       = r_ct;
        w_done_nxt     = 1'b0;
        w_data_in_nxt  = 1'b0;
        w_data_rdy_nxt = r_data_rdy;
`ifdef SIMON_CTRL_TIMEOUT_EN
        w_err_nxt      = r_err;
`endif
        case (r_state)
            S_IDLE: begin
                w_data_rdy_nxt = MODE_IDLE;
                if (start) begin
                    w_state_nxt    = S_LOAD_KEY;
                    w_cnt_nxt      = '0;
                    w_key_sr_nxt   = key[KEY_BITS-1:1];
                    w_pt_sr_nxt    = pt;
                    w_data_in_nxt  = key[0];
                    w_data_rdy_nxt = MODE_KEY;
`ifdef SIMON_CTRL_TIMEOUT_EN
                    w_err_nxt      = 1'b0;
`endif
                end
            end
            S_LOAD_KEY: begin
                if (r_cnt == KEY_LAST) begin
                    w_state_nxt    = S_LOAD_PT;
                    w_cnt_nxt      = '0;
                    w_data_in_nxt  = r_pt_sr[0];
                    w_data_rdy_nxt = MODE_PT;
                end else begin
                    w_cnt_nxt      = r_cnt + CNT_W'(1);
                    w_key_sr_nxt   = r_key_sr >> 1;
                    w_data_in_nxt  = r_key_sr[0];
                end
            end
            S_LOAD_PT: begin
                if (r_cnt == PT_LAST) begin
                    w_state_nxt    = S_RUN;
                    w_cnt_nxt      = '0;
                    w_data_rdy_nxt = MODE_RUN;
                end else begin
                    w_cnt_nxt      = r_cnt + CNT_W'(1);
                    w_pt_sr_nxt    = r_pt_sr >> 1;
                    w_data_in_nxt  = r_pt_sr[1];
                end
            end
            S_RUN: begin
                if (core_valid) begin
                    w_state_nxt    = S_UNLOAD;
                    w_cnt_nxt      = '0;
                    w_ct_sr_nxt    = {core_cipher_out, r_ct_sr[BLOCK_BITS-2:1]};
                end
`ifdef SIMON_CTRL_TIMEOUT_EN
                else if (r_cnt == RUN_LAST) begin
                    w_state_nxt    = S_DONE;
                    w_cnt_nxt      = '0;
                    w_err_nxt      = 1'b1;
                    w_done_nxt     = 1'b1;
                    w_data_rdy_nxt = MODE_IDLE;
                end else begin
                    w_cnt_nxt      = r_cnt + CNT_W'(1);
                end
`endif
            end
            // Ciphertext enters at the MSB so the first sampled bit ends up in bit 0.
            S_UNLOAD: begin
                w_ct_sr_nxt = {core_cipher_out, r_ct_sr[BLOCK_BITS-2:1]};
                if (r_cnt == UNLOAD_LAST) begin
                    w_state_nxt    = S_DONE;
                    w_cnt_nxt      = '0;
                    w_ct_nxt       = {core_cipher_out, r_ct_sr};
                    w_done_nxt     = 1'b1;
                    w_data_rdy_nxt = MODE_IDLE;
                end else begin
                    w_cnt_nxt      = r_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt    = S_IDLE;
                w_cnt_nxt      = '0;
                w_data_rdy_nxt = MODE_IDLE;
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_cnt_nxt      = '0;
                w_data_rdy_nxt = MODE_IDLE;
            end
        endcase
    end

    assign w_busy_nxt = (w_state_nxt != S_IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_key_sr   <= '0;
            r_pt_sr    <= '0;
            r_ct_sr    <= '0;
            r_ct       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_data_in  <= 1'b0;
            r_data_rdy <= MODE_IDLE;
`ifdef SIMON_CTRL_TIMEOUT_EN
            r_err      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_key_sr   <= w_key_sr_nxt;
            r_pt_sr    <= w_pt_sr_nxt;
            r_ct_sr    <= w_ct_sr_nxt;
            r_ct       <= w_ct_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_data_in  <= w_data_in_nxt;
            r_data_rdy <= w_data_rdy_nxt;
`ifdef SIMON_CTRL_TIMEOUT_EN
            r_err      <= w_err_nxt;
`endif
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign ct            = r_ct;
    assign core_data_in  = r_data_in;
    assign core_data_rdy = r_data_rdy;
`ifdef SIMON_CTRL_TIMEOUT_EN
    assign err           = r_err;
`else
    assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_simon_ctrl.sv
// tb_simon_ctrl: self-checking bench for simon_ctrl with a simple serial core stand-in and a timeline-based reference model.
// Honours SIMON_CTRL_TIMEOUT_EN the same way as the design.

module tb_simon_ctrl;

    localparam int K  = 128;
    localparam int B  = 64;
    localparam int TO = 16;
`ifdef SIMON_CTRL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [K-1:0] key;
    logic [B-1:0] pt;
    logic         busy, done, err;
    logic [B-1:0] ct;
    logic         core_data_in;
    logic [1:0]   core_data_rdy;
    logic         core_cipher_out = 1'b0;
    logic         core_valid = 1'b0;

    int checks = 0;
    int failures = 0;
    bit checkEn = 1'b0;

    simon_ctrl #(.BLOCK_BITS(B), .KEY_BITS(K), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .key(key), .pt(pt),
        .busy(busy), .done(done), .err(err), .ct(ct),
        .core_data_in(core_data_in), .core_data_rdy(core_data_rdy),
        .core_cipher_out(core_cipher_out), .core_valid(core_valid)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Core stand-in: raises valid coreDelay cycles into RUN, then streams coreWord LSB first.
    int           coreDelay = 0;
    logic [B-1:0] coreWord = '0;
    bit           corePulse = 1'b0;
    bit           coreNever = 1'b1;
    int           runCnt = 0;
    int           coreIdx;
    always @(negedge clk) begin
        if (core_data_rdy == 2'b11) runCnt++;
        else runCnt = 0;
        core_valid = 1'b0;
        core_cipher_out = 1'($urandom);
        if (runCnt > 0 && !coreNever) begin
            coreIdx = runCnt - 1;
            if (coreIdx == coreDelay || (!corePulse && coreIdx > coreDelay)) core_valid = 1'b1;
            if (coreIdx >= coreDelay && coreIdx < coreDelay + B)
                core_cipher_out = coreWord[coreIdx - coreDelay];
        end
    end

    // Reference model: t counts edges since the accepting edge; outputs follow from where t falls.
    bit           active = 1'b0;
    int           t;
    int           nBits;
    bit           vSeen;
    logic [K-1:0] mKey;
    logic [B-1:0] mPt, mCt, ctAcc;
    logic         mBusy = 1'b0, mDone = 1'b0, mErr = 1'b0, mDin = 1'b0;
    logic [1:0]   mRdy = 2'b00;
    always @(posedge clk) begin
        if (!reset) begin
            active = 1'b0; mBusy = 1'b0; mDone = 1'b0; mErr = 1'b0;
            mCt = '0; mRdy = 2'b00; mDin = 1'b0;
        end else if (!active) begin
            mDone = 1'b0; mBusy = 1'b0; mRdy = 2'b00; mDin = 1'b0;
            if (start) begin
                active = 1'b1; t = 0; mKey = key; mPt = pt; mErr = 1'b0;
                vSeen = 1'b0; nBits = 0; mBusy = 1'b1; mRdy = 2'b01; mDin = key[0];
            end
        end else if (mDone) begin
            active = 1'b0; mDone = 1'b0; mBusy = 1'b0; mRdy = 2'b00; mDin = 1'b0;
        end else begin
            t++;
            if (t < K) begin
                mRdy = 2'b01; mDin = mKey[t];
            end else if (t < K + B) begin
                mRdy = 2'b10; mDin = mPt[t - K];
            end else begin
                mRdy = 2'b11; mDin = 1'b0;
                if (t > K + B) begin
                    if (vSeen || core_valid) begin
                        vSeen = 1'b1;
                        ctAcc[nBits] = core_cipher_out;
                        nBits++;
                        if (nBits == B) begin
                            mCt = ctAcc; mDone = 1'b1; mRdy = 2'b00;
                        end
                    end else if (TO_EN && t == K + B + TO) begin
                        mErr = 1'b1; mDone = 1'b1; mRdy = 2'b00;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("busy", 128'(busy), 128'(mBusy));
            checkOutput("done", 128'(done), 128'(mDone));
            checkOutput("err", 128'(err), 128'(mErr));
            checkOutput("ct", 128'(ct), 128'(mCt));
            checkOutput("data_rdy", 128'(core_data_rdy), 128'(mRdy));
            checkOutput("data_in", 128'(core_data_in), 128'(mDin));
        end
    end

    bit holdStart = 1'b0;
    task automatic applyStimulus(input logic [K-1:0] k, input logic [B-1:0] p, input int delay,
                                 input logic [B-1:0] word, input bit pulse, input bit never);
        int n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_before_start", 128'(busy), 128'(0));
        coreDelay = delay; coreWord = word; corePulse = pulse; coreNever = never;
        key = k; pt = p; start = 1'b1;
        @(negedge clk);
        if (!holdStart) start = 1'b0;
    endtask

    int doneEdge, keyCnt, keyOnes, keyPos, ptCnt, ptOnes, ptPos;
    task automatic waitDone(input int limit);
        int e = 0;
        doneEdge = -1; keyCnt = 0; keyOnes = 0; keyPos = -1; ptCnt = 0; ptOnes = 0; ptPos = -1;
        while (e < limit) begin
            if (core_data_rdy == 2'b01) begin
                if (core_data_in) begin keyOnes++; keyPos = keyCnt; end
                keyCnt++;
            end else if (core_data_rdy == 2'b10) begin
                if (core_data_in) begin ptOnes++; ptPos = ptCnt; end
                ptCnt++;
            end
            if (done) begin
                doneEdge = e + 1;
                break;
            end
            @(negedge clk);
            e++;
        end
        checkOutput("done_seen", 128'(doneEdge >= 0), 128'(1));
    endtask

    initial begin
        logic [K-1:0] rk;
        logic [B-1:0] rp, rw, word1;
        int           rd, idle, n;
        reset = 1'b0; start = 1'b0; key = '0; pt = '0;
        repeat (3) @(negedge clk);
        checkEn = 1'b1;
        checkOutput("reset_busy", 128'(busy), 128'(0));
        checkOutput("reset_done", 128'(done), 128'(0));
        checkOutput("reset_rdy", 128'(core_data_rdy), 128'(0));
        checkOutput("reset_ct", 128'(ct), 128'(0));
        reset = 1'b1;
        @(negedge clk);

        // Reset asserted during the 10th LOAD_PT cycle.
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}, 5,
                      {$urandom, $urandom}, 1'b0, 1'b0);
        repeat (K + 9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midreset_busy", 128'(busy), 128'(0));
        checkOutput("midreset_rdy", 128'(core_data_rdy), 128'(0));
        checkOutput("midreset_ct", 128'(ct), 128'(0));
        reset = 1'b1;

        // Nominal encryption.
        applyStimulus('0, 64'h6565_6877_2074_6869, 20, 64'hC69B_E9BB_6D6F_7A3F, 1'b0, 1'b0);
        waitDone(1000);
        checkOutput("nom_done_edge", 128'(doneEdge), 128'(277));
        checkOutput("nom_ct", 128'(ct), 128'(64'hC69B_E9BB_6D6F_7A3F));
        checkOutput("nom_key_cycles", 128'(keyCnt), 128'(128));
        checkOutput("nom_pt_cycles", 128'(ptCnt), 128'(64));

        // Serial bit ordering.
        rw = {$urandom, $urandom};
        applyStimulus(128'h1, 64'h8000_0000_0000_0000, 3, rw, 1'b1, 1'b0);
        waitDone(1000);
        checkOutput("ord_key_ones", 128'(keyOnes), 128'(1));
        checkOutput("ord_key_pos", 128'(keyPos), 128'(0));
        checkOutput("ord_pt_ones", 128'(ptOnes), 128'(1));
        checkOutput("ord_pt_pos", 128'(ptPos), 128'(63));
        checkOutput("ord_ct", 128'(ct), 128'(rw));

        // Valid on the first RUN cycle, start held high across two transactions.
        word1 = {$urandom, $urandom};
        holdStart = 1'b1;
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}, 0, word1, 1'b0, 1'b0);
        waitDone(1000);
        checkOutput("imm_done_edge", 128'(doneEdge), 128'(257));
        checkOutput("imm_ct", 128'(ct), 128'(word1));
        holdStart = 1'b0;
        idle = 0; n = 0;
        @(negedge clk);
        while (!busy && n < 10) begin
            idle++;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        checkOutput("held_idle_cycles", 128'(idle), 128'(1));
        waitDone(1000);
        checkOutput("held_done_edge", 128'(doneEdge), 128'(257));

`ifdef SIMON_CTRL_TIMEOUT_EN
        // Timeout: err set, ct kept, next start clears err.
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}, 0,
                      {$urandom, $urandom}, 1'b0, 1'b1);
        waitDone(1000);
        checkOutput("to_done_edge", 128'(doneEdge), 128'(209));
        checkOutput("to_err", 128'(err), 128'(1));
        checkOutput("to_ct_kept", 128'(ct), 128'(word1));
        rw = {$urandom, $urandom};
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}, 7, rw, 1'b0, 1'b0);
        checkOutput("to_err_cleared", 128'(err), 128'(0));
        waitDone(1000);
        checkOutput("to_next_ct", 128'(ct), 128'(rw));
`else
        // No timeout: RUN waits indefinitely until reset.
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}, 0,
                      {$urandom, $urandom}, 1'b0, 1'b1);
        repeat (1000) @(negedge clk);
        checkOutput("notimeout_busy", 128'(busy), 128'(1));
        checkOutput("notimeout_err", 128'(err), 128'(0));
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
`endif

        // Randomized transactions.
        for (int i = 0; i < 8; i++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            rp = {$urandom, $urandom};
            rw = {$urandom, $urandom};
            rd = int'($urandom_range(0, 40));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            applyStimulus(rk, rp, rd, rw, 1'($urandom_range(0, 1)), 1'b0);
            waitDone(1000);
            checkOutput("rand_done_edge", 128'(doneEdge), 128'(K + B + 1 + rd + B));
            checkOutput("rand_ct", 128'(ct), 128'(rw));
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
